// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcode/funct/rt
// constants, ALU operation codes, datapath mux selects and the instruction class.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_NONE   = 4'd0,
        CL_J      = 4'd1,
        CL_JR     = 4'd2,
        CL_JAL    = 4'd3,
        CL_JALR   = 4'd4,
        CL_BRANCH = 4'd5,
        CL_BGEZAL = 4'd6,
        CL_LOAD   = 4'd7,
        CL_STORE  = 4'd8,
        CL_ALU    = 4'd9
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09, OP_SLTI   = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI    = 6'h0f, OP_LW     = 6'h23, OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27, FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BGEZAL = 5'h11;

    localparam logic [4:0] ALU_BLTZ = 5'b00000, ALU_BGEZ = 5'b00001, ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00011, ALU_AND  = 5'b00100, ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_XOR  = 5'b00110, ALU_NOR  = 5'b00111, ALU_SRL  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001, ALU_SLL  = 5'b01010, ALU_BNE  = 5'b01011;
    localparam logic [4:0] ALU_SLT  = 5'b01100, ALU_SLTU = 5'b01101, ALU_BLEZ = 5'b01110;
    localparam logic [4:0] ALU_BGTZ = 5'b01111;

    localparam logic [1:0] PC_SRC_PC4 = 2'd0, PC_SRC_BRANCH = 2'd1, PC_SRC_JUMP = 2'd2, PC_SRC_RS = 2'd3;
    localparam logic [1:0] REG_DST_RT = 2'd0, REG_DST_RD = 2'd1, REG_DST_RA = 2'd2;
    localparam logic [1:0] M2R_ALU = 2'd0, M2R_MEM = 2'd1, M2R_LINK = 2'd2;
    localparam logic [1:0] ALU_SRC_RT = 2'd0, ALU_SRC_IMM = 2'd1, ALU_SRC_SHAMT = 2'd2;
    localparam logic [1:0] EXT_SIGN = 2'd0, EXT_ZERO = 2'd1, EXT_UPPER = 2'd2, EXT_BRANCH = 2'd3;

    typedef struct packed {
        instr_class_t cls;
        logic [4:0]   alu_ctrl;
        logic [1:0]   alu_src;
        logic [1:0]   ext_op;
        logic [1:0]   reg_dst;
        logic         link;
    } decode_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle sequencer (master) and the MIPS datapath (slave).
interface mc_ctrl_if;
    logic [31:0] cmd;
    logic        br_cond;
    logic        mem_ready;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic [1:0]  alu_src;
    logic [1:0]  ext_op;
    logic [4:0]  alu_ctrl;
    logic [2:0]  state;
    logic [31:0] retired;

    modport master (
        input  cmd, br_cond, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
               reg_dst, mem_to_reg, alu_src, ext_op, alu_ctrl, state, retired
    );

    modport slave (
        output cmd, br_cond, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
               reg_dst, mem_to_reg, alu_src, ext_op, alu_ctrl, state, retired
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: maps the IR word to its class and the
// per-class ALU code, operand/extension selects, destination select and link flag.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] cmd,
    output decode_t     dec
);

    logic [5:0] op_s;
    logic [5:0] funct_s;
    logic [4:0] rt_s;

    assign op_s    = cmd[31:26];
    assign funct_s = cmd[5:0];
    assign rt_s    = cmd[20:16];

    // Class and per-class datapath selects; an all-zero word is a nop, not sll.
    always_comb begin
        dec = '{cls: CL_NONE, alu_ctrl: ALU_BLTZ, alu_src: ALU_SRC_RT,
                ext_op: EXT_SIGN, reg_dst: REG_DST_RT, link: 1'b0};
        if (cmd != 32'd0) begin
            case (op_s)
                OP_RTYPE: begin
                    dec.cls     = CL_ALU;
                    dec.reg_dst = REG_DST_RD;
                    case (funct_s)
                        FN_SLL:          begin dec.alu_ctrl = ALU_SLL; dec.alu_src = ALU_SRC_SHAMT; end
                        FN_SRL:          begin dec.alu_ctrl = ALU_SRL; dec.alu_src = ALU_SRC_SHAMT; end
                        FN_SRA:          begin dec.alu_ctrl = ALU_SRA; dec.alu_src = ALU_SRC_SHAMT; end
                        FN_SLLV:         dec.alu_ctrl = ALU_SLL;
                        FN_SRLV:         dec.alu_ctrl = ALU_SRL;
                        FN_SRAV:         dec.alu_ctrl = ALU_SRA;
                        FN_JR:           dec.cls = CL_JR;
                        FN_JALR:         begin dec.cls = CL_JALR; dec.link = 1'b1; end
                        FN_ADD, FN_ADDU: dec.alu_ctrl = ALU_ADD;
                        FN_SUB, FN_SUBU: dec.alu_ctrl = ALU_SUB;
                        FN_AND:          dec.alu_ctrl = ALU_AND;
                        FN_OR:           dec.alu_ctrl = ALU_OR;
                        FN_XOR:          dec.alu_ctrl = ALU_XOR;
                        FN_NOR:          dec.alu_ctrl = ALU_NOR;
                        FN_SLT:          dec.alu_ctrl = ALU_SLT;
                        FN_SLTU:         dec.alu_ctrl = ALU_SLTU;
                        default:         begin dec.cls = CL_NONE; dec.reg_dst = REG_DST_RT; end
                    endcase
                end
                OP_REGIMM: begin
                    dec.ext_op = EXT_BRANCH;
                    case (rt_s)
                        RT_BLTZ:   begin dec.cls = CL_BRANCH; dec.alu_ctrl = ALU_BLTZ; end
                        RT_BGEZ:   begin dec.cls = CL_BRANCH; dec.alu_ctrl = ALU_BGEZ; end
                        RT_BGEZAL: begin
                            dec.cls      = CL_BGEZAL;
                            dec.alu_ctrl = ALU_BGEZ;
                            dec.reg_dst  = REG_DST_RA;
                            dec.link     = 1'b1;
                        end
                        default:   begin dec.cls = CL_NONE; dec.ext_op = EXT_SIGN; end
                    endcase
                end
                OP_J:     dec.cls = CL_J;
                OP_JAL:   begin dec.cls = CL_JAL; dec.reg_dst = REG_DST_RA; dec.link = 1'b1; end
                OP_BEQ:   begin dec.cls = CL_BRANCH; dec.alu_ctrl = ALU_SUB;  dec.ext_op = EXT_BRANCH; end
                OP_BNE:   begin dec.cls = CL_BRANCH; dec.alu_ctrl = ALU_BNE;  dec.ext_op = EXT_BRANCH; end
                OP_BLEZ:  begin dec.cls = CL_BRANCH; dec.alu_ctrl = ALU_BLEZ; dec.ext_op = EXT_BRANCH; end
                OP_BGTZ:  begin dec.cls = CL_BRANCH; dec.alu_ctrl = ALU_BGTZ; dec.ext_op = EXT_BRANCH; end
                OP_ADDI, OP_ADDIU: begin dec.cls = CL_ALU; dec.alu_ctrl = ALU_ADD;  dec.alu_src = ALU_SRC_IMM; end
                OP_SLTI:  begin dec.cls = CL_ALU; dec.alu_ctrl = ALU_SLT;  dec.alu_src = ALU_SRC_IMM; end
                OP_SLTIU: begin dec.cls = CL_ALU; dec.alu_ctrl = ALU_SLTU; dec.alu_src = ALU_SRC_IMM; end
                OP_ANDI:  begin dec.cls = CL_ALU; dec.alu_ctrl = ALU_AND; dec.alu_src = ALU_SRC_IMM; dec.ext_op = EXT_ZERO; end
                OP_ORI:   begin dec.cls = CL_ALU; dec.alu_ctrl = ALU_OR;  dec.alu_src = ALU_SRC_IMM; dec.ext_op = EXT_ZERO; end
                OP_XORI:  begin dec.cls = CL_ALU; dec.alu_ctrl = ALU_XOR; dec.alu_src = ALU_SRC_IMM; dec.ext_op = EXT_ZERO; end
                OP_LUI:   begin dec.cls = CL_ALU; dec.alu_ctrl = ALU_ADD; dec.alu_src = ALU_SRC_IMM; dec.ext_op = EXT_UPPER; end
                OP_LW:    begin dec.cls = CL_LOAD;  dec.alu_ctrl = ALU_ADD; dec.alu_src = ALU_SRC_IMM; end
                OP_SW:    begin dec.cls = CL_STORE; dec.alu_ctrl = ALU_ADD; dec.alu_src = ALU_SRC_IMM; end
                default:  dec.cls = CL_NONE;
            endcase
        end else begin
            dec.cls = CL_NONE;
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS sequencer: Moore FSM INIT/FETCH/DECODE/EXEC/MEM/WB plus retired counter.
// Optional CTRL_MEM_HANDSHAKE_EN stretches FETCH and MEM until mem_ready.
module mc_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    mc_ctrl_if.master bus
);

    state_t      state_r;
    state_t      nstate_s;
    logic [31:0] retired_r;
    decode_t     dec_s;
    logic        mem_ok_s;
    logic        retire_s;

    mc_ctrl_decode u_decode (
        .cmd (bus.cmd),
        .dec (dec_s)
    );

`ifdef CTRL_MEM_HANDSHAKE_EN
    assign mem_ok_s = bus.mem_ready;
`else
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = bus.mem_ready;
    assign mem_ok_s = 1'b1;
`endif

    // Next state and per-state datapath controls.
    always_comb begin
        nstate_s       = state_r;
        bus.pc_write   = 1'b0;
        bus.pc_src     = PC_SRC_PC4;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = REG_DST_RT;
        bus.mem_to_reg = M2R_ALU;
        bus.alu_src    = ALU_SRC_RT;
        bus.ext_op     = EXT_SIGN;
        bus.alu_ctrl   = ALU_BLTZ;
        case (state_r)
            S_INIT: nstate_s = S_FETCH;
            S_FETCH: begin
                bus.mem_read = 1'b1;
                bus.ir_write = mem_ok_s;
                bus.pc_write = mem_ok_s;
                if (mem_ok_s) nstate_s = S_DECODE;
                else          nstate_s = S_FETCH;
            end
            S_DECODE: begin
                case (dec_s.cls)
                    CL_J:    begin bus.pc_write = 1'b1; bus.pc_src = PC_SRC_JUMP; nstate_s = S_FETCH; end
                    CL_JR:   begin bus.pc_write = 1'b1; bus.pc_src = PC_SRC_RS;   nstate_s = S_FETCH; end
                    CL_JAL:  begin bus.pc_write = 1'b1; bus.pc_src = PC_SRC_JUMP; nstate_s = S_WB;    end
                    CL_JALR: begin bus.pc_write = 1'b1; bus.pc_src = PC_SRC_RS;   nstate_s = S_WB;    end
                    CL_NONE: nstate_s = S_FETCH;
                    default: nstate_s = S_EXEC;
                endcase
            end
            S_EXEC: begin
                bus.alu_src  = dec_s.alu_src;
                bus.ext_op   = dec_s.ext_op;
                bus.alu_ctrl = dec_s.alu_ctrl;
                case (dec_s.cls)
                    CL_BRANCH: begin bus.pc_write = bus.br_cond; bus.pc_src = PC_SRC_BRANCH; nstate_s = S_FETCH; end
                    CL_BGEZAL: begin bus.pc_write = bus.br_cond; bus.pc_src = PC_SRC_BRANCH; nstate_s = S_WB;    end
                    CL_LOAD, CL_STORE: nstate_s = S_MEM;
                    CL_ALU:    nstate_s = S_WB;
                    default:   nstate_s = S_FETCH;
                endcase
            end
            S_MEM: begin
                // ALU controls stay at their EXEC values so the memory address is stable.
                bus.iord     = 1'b1;
                bus.alu_src  = dec_s.alu_src;
                bus.ext_op   = dec_s.ext_op;
                bus.alu_ctrl = dec_s.alu_ctrl;
                case (dec_s.cls)
                    CL_LOAD: begin
                        bus.mem_read = 1'b1;
                        if (mem_ok_s) nstate_s = S_WB;
                        else          nstate_s = S_MEM;
                    end
                    CL_STORE: begin
                        bus.mem_write = 1'b1;
                        if (mem_ok_s) nstate_s = S_FETCH;
                        else          nstate_s = S_MEM;
                    end
                    default: nstate_s = S_FETCH;
                endcase
            end
            S_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = dec_s.reg_dst;
                bus.alu_src   = dec_s.alu_src;
                bus.ext_op    = dec_s.ext_op;
                bus.alu_ctrl  = dec_s.alu_ctrl;
                if (dec_s.link)                bus.mem_to_reg = M2R_LINK;
                else if (dec_s.cls == CL_LOAD) bus.mem_to_reg = M2R_MEM;
                else                           bus.mem_to_reg = M2R_ALU;
                nstate_s = S_FETCH;
            end
            default: nstate_s = S_INIT;
        endcase
    end

    // An instruction ends on any entry into FETCH except from INIT or a held FETCH.
    assign retire_s = (nstate_s == S_FETCH) && (state_r != S_INIT) && (state_r != S_FETCH);

    // State register and retired-instruction counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_INIT;
            retired_r <= 32'd0;
        end else begin
            state_r <= nstate_s;
            if (retire_s) retired_r <= retired_r + 32'd1;
        end
    end

    assign bus.state   = state_r;
    assign bus.retired = retired_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against an instruction-level phase model.
module tb_mc_ctrl;

    localparam int K_NONE = 0, K_J = 1, K_JR = 2, K_JAL = 3, K_JALR = 4;
    localparam int K_BR = 5, K_BAL = 6, K_LD = 7, K_ST = 8, K_ALU = 9;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src;
        logic [1:0] ext_op;
        logic [4:0] alu_ctrl;
    } outs_t;

    typedef struct {
        int         kind;
        logic [4:0] alu;
        logic [1:0] asrc;
        logic [1:0] ext;
        logic [1:0] rdst;
    } info_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_retired = 32'd0;

    logic [5:0] fn_tab [19] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20,
                                6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h3f};
    logic [5:0] op_tab [17] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0a,
                                6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h3f};
    logic [4:0] rt_tab [4]  = '{5'h00, 5'h01, 5'h11, 5'h10};

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic outs_t observe();
        outs_t o;
        o.state = bus.state;         o.pc_write = bus.pc_write;   o.pc_src = bus.pc_src;
        o.ir_write = bus.ir_write;   o.mem_read = bus.mem_read;   o.mem_write = bus.mem_write;
        o.iord = bus.iord;           o.reg_write = bus.reg_write; o.reg_dst = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg; o.alu_src = bus.alu_src;   o.ext_op = bus.ext_op;
        o.alu_ctrl = bus.alu_ctrl;
        return o;
    endfunction

    // Instruction-set rules: class, ALU code, operand select, extension and destination.
    function automatic info_t classify(input logic [31:0] c);
        info_t i;
        i = '{kind: K_NONE, alu: 5'd0, asrc: 2'd0, ext: 2'd0, rdst: 2'd0};
        if (c == 32'd0) return i;
        case (c[31:26])
            6'h00: begin
                i.kind = K_ALU; i.rdst = 2'd1;
                case (c[5:0])
                    6'h00: begin i.alu = 5'b01010; i.asrc = 2'd2; end
                    6'h02: begin i.alu = 5'b01000; i.asrc = 2'd2; end
                    6'h03: begin i.alu = 5'b01001; i.asrc = 2'd2; end
                    6'h04: i.alu = 5'b01010;
                    6'h06: i.alu = 5'b01000;
                    6'h07: i.alu = 5'b01001;
                    6'h08: i.kind = K_JR;
                    6'h09: i.kind = K_JALR;
                    6'h20, 6'h21: i.alu = 5'b00010;
                    6'h22, 6'h23: i.alu = 5'b00011;
                    6'h24: i.alu = 5'b00100;
                    6'h25: i.alu = 5'b00101;
                    6'h26: i.alu = 5'b00110;
                    6'h27: i.alu = 5'b00111;
                    6'h2a: i.alu = 5'b01100;
                    6'h2b: i.alu = 5'b01101;
                    default: i.kind = K_NONE;
                endcase
            end
            6'h01: begin
                i.ext = 2'd3;
                case (c[20:16])
                    5'h00: begin i.kind = K_BR;  i.alu = 5'b00000; end
                    5'h01: begin i.kind = K_BR;  i.alu = 5'b00001; end
                    5'h11: begin i.kind = K_BAL; i.alu = 5'b00001; i.rdst = 2'd2; end
                    default: i.kind = K_NONE;
                endcase
            end
            6'h02: i.kind = K_J;
            6'h03: begin i.kind = K_JAL; i.rdst = 2'd2; end
            6'h04: begin i.kind = K_BR; i.alu = 5'b00011; i.ext = 2'd3; end
            6'h05: begin i.kind = K_BR; i.alu = 5'b01011; i.ext = 2'd3; end
            6'h06: begin i.kind = K_BR; i.alu = 5'b01110; i.ext = 2'd3; end
            6'h07: begin i.kind = K_BR; i.alu = 5'b01111; i.ext = 2'd3; end
            6'h08, 6'h09: begin i.kind = K_ALU; i.alu = 5'b00010; i.asrc = 2'd1; end
            6'h0a: begin i.kind = K_ALU; i.alu = 5'b01100; i.asrc = 2'd1; end
            6'h0b: begin i.kind = K_ALU; i.alu = 5'b01101; i.asrc = 2'd1; end
            6'h0c: begin i.kind = K_ALU; i.alu = 5'b00100; i.asrc = 2'd1; i.ext = 2'd1; end
            6'h0d: begin i.kind = K_ALU; i.alu = 5'b00101; i.asrc = 2'd1; i.ext = 2'd1; end
            6'h0e: begin i.kind = K_ALU; i.alu = 5'b00110; i.asrc = 2'd1; i.ext = 2'd1; end
            6'h0f: begin i.kind = K_ALU; i.alu = 5'b00010; i.asrc = 2'd1; i.ext = 2'd2; end
            6'h23: begin i.kind = K_LD;  i.alu = 5'b00010; i.asrc = 2'd1; end
            6'h2b: begin i.kind = K_ST;  i.alu = 5'b00010; i.asrc = 2'd1; end
            default: i.kind = K_NONE;
        endcase
        return i;
    endfunction

    // Expected outputs for one cycle of a given phase (1 FETCH .. 5 WB).
    function automatic outs_t expect_out(input int ph, input info_t i, input logic brc, input logic rdy);
        outs_t o;
        o = '0;
        o.state = 3'(ph);
        if (ph >= 3) begin
            o.alu_ctrl = i.alu; o.alu_src = i.asrc; o.ext_op = i.ext;
        end
        case (ph)
            1: begin o.mem_read = 1'b1; o.ir_write = rdy; o.pc_write = rdy; end
            2: begin
                if (i.kind == K_J || i.kind == K_JAL)   begin o.pc_write = 1'b1; o.pc_src = 2'd2; end
                if (i.kind == K_JR || i.kind == K_JALR) begin o.pc_write = 1'b1; o.pc_src = 2'd3; end
            end
            3: if (i.kind == K_BR || i.kind == K_BAL) begin o.pc_write = brc; o.pc_src = 2'd1; end
            4: begin o.iord = 1'b1; o.mem_read = (i.kind == K_LD); o.mem_write = (i.kind == K_ST); end
            5: begin
                o.reg_write = 1'b1;
                o.reg_dst = i.rdst;
                if (i.kind == K_JAL || i.kind == K_JALR || i.kind == K_BAL) o.mem_to_reg = 2'd2;
                else if (i.kind == K_LD) o.mem_to_reg = 2'd1;
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_value("rst/outs", 32'(observe()), 32'd0);
        check_value("rst/retired", bus.retired, 32'd0);
        exp_retired = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_value("rst/init", 32'(observe()), 32'd0);
    endtask

    // brc_mode <0 random; mem_wait <0 random-but-bounded ready, else MEM-ready delay;
    // abort_ph pulls reset on the first cycle of that phase.
    task automatic run_instr(input logic [31:0] c, input string tag, input int brc_mode,
                             input int mem_wait, input int abort_ph);
        info_t i;
        int    phases[$];
        i = classify(c);
        phases.push_back(1);
        phases.push_back(2);
        if (i.kind inside {K_BR, K_BAL, K_LD, K_ST, K_ALU}) phases.push_back(3);
        if (i.kind inside {K_LD, K_ST}) phases.push_back(4);
        if (i.kind inside {K_ALU, K_LD, K_JAL, K_JALR, K_BAL}) phases.push_back(5);
        foreach (phases[k]) begin
            int   ph;
            int   waited;
            logic brc;
            logic mr;
            logic rdy;
            ph = phases[k];
            waited = 0;
            do begin
                @(negedge clk);
                brc = (brc_mode < 0) ? 1'($urandom) : 1'(brc_mode);
                if (mem_wait < 0) mr = (waited >= 3) ? 1'b1 : 1'($urandom);
                else              mr = (ph == 4) ? (waited >= mem_wait) : 1'b1;
                bus.cmd = c;
                bus.br_cond = brc;
                bus.mem_ready = mr;
                #1;
`ifdef CTRL_MEM_HANDSHAKE_EN
                rdy = (ph == 1 || ph == 4) ? mr : 1'b1;
`else
                rdy = 1'b1;
`endif
                check_value($sformatf("%s/p%0d", tag, ph), 32'(observe()), 32'(expect_out(ph, i, brc, rdy)));
                if (ph == 1 && waited == 0)
                    check_value({tag, "/retired"}, bus.retired, exp_retired);
                if (ph == abort_ph) begin
                    reset_n = 1'b0;
                    #1;
                    check_value({tag, "/abort"}, 32'(observe()), 32'd0);
                    check_value({tag, "/abort_ret"}, bus.retired, 32'd0);
                    exp_retired = 32'd0;
                    @(negedge clk);
                    reset_n = 1'b1;
                    #1;
                    check_value({tag, "/abort_init"}, 32'(observe()), 32'd0);
                    return;
                end
                waited++;
            end while (!rdy);
        end
        exp_retired++;
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [31:0] c;
        int          sel;
        c = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 3) begin
            c[31:26] = 6'h00;
            c[5:0] = fn_tab[$urandom_range(0, 18)];
        end else if (sel == 3) begin
            c[31:26] = 6'h01;
            c[20:16] = rt_tab[$urandom_range(0, 3)];
        end else if (sel < 9) begin
            c[31:26] = op_tab[$urandom_range(0, 16)];
        end
        return c;
    endfunction

    initial begin
        bus.cmd = 32'd0;
        bus.br_cond = 1'b0;
        bus.mem_ready = 1'b0;
        do_reset();
        run_instr(32'h0022_1821, "addu", -1, -1, -1);
        run_instr(32'h8C22_0004, "lw", -1, 2, -1);
        run_instr(32'h1022_0008, "beq_t", 1, -1, -1);
        run_instr(32'h1022_0008, "beq_n", 0, -1, -1);
        run_instr(32'h0C10_0004, "jal", -1, -1, -1);
        run_instr(32'hFC00_0000, "op3f", -1, -1, -1);
        run_instr(32'h0000_0000, "nop", -1, -1, -1);
        run_instr(32'hAC22_0008, "sw_abort", -1, -1, 4);
        run_instr(32'hAC22_0008, "sw", -1, -1, -1);
        for (int n = 0; n < 300; n++) begin
            int ab;
            ab = ($urandom_range(0, 24) == 0) ? $urandom_range(1, 5) : -1;
            run_instr(rand_cmd(), $sformatf("rnd%0d", n), -1, -1, ab);
        end
        @(negedge clk);
        #1;
        check_value("final/state", 32'(bus.state), 32'd1);
        check_value("final/retired", bus.retired, exp_retired);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencer for the MIPS datapath. It replaces per-instruction single-cycle control with a Moore FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB, so the ALU and the unified memory port are shared across cycles. It sits between the instruction register, the ALU flags and memory. It drives every write strobe and mux select of the datapath and keeps a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd  in  32  instruction register contents; valid from DECODE onward.
- br_cond  in  1  ALU branch-condition result for the current ALUCtrl.
- mem_ready  in  1  memory access done this cycle; used only with CTRL_MEM_HANDSHAKE_EN.
- pc_write  out  1  PC load strobe.
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target {PC[31:28],cmd[25:0],00}, 3 rs (jr/jalr).
- ir_write  out  1  IR load strobe.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  memory address source: 0 PC, 1 ALU result.
- reg_write  out  1  register-file write strobe.
- reg_dst  out  2  0 rt, 1 rd, 2 $31.
- mem_to_reg  out  2  0 ALU result, 1 memory data, 2 link (PC+4).
- alu_src  out  2  0 rt, 1 extended immediate, 2 shamt.
- ext_op  out  2  0 sign, 1 zero, 2 upper-16 (lui), 3 sign<<2 (branch).
- alu_ctrl  out  5  ALU operation code from the shared ALU code set.
- state  out  3  current state, for debug.
- retired  out  32  count of completed instructions.

## Operation
- States: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Reset enters INIT. INIT always goes to FETCH on the next edge.
- INIT: every strobe is 0.
- FETCH: asserts mem_read, iord=0, ir_write=1, pc_write=1, pc_src=0. Goes to DECODE.
- DECODE: classifies cmd.
  - j / jr: asserts pc_write with pc_src 2 / 3. Goes to FETCH and retires.
  - jal / jalr: asserts pc_write with pc_src 2 / 3. Goes to WB.
  - cmd==0 or an unknown opcode/funct: asserts nothing. Goes to FETCH and retires.
  - All other classes go to EXEC.
- EXEC: drives alu_src, ext_op and alu_ctrl for the class.
  - Branch: pc_write=br_cond, pc_src=1. bgezal goes to WB; other branches go to FETCH and retire.
  - Load/store: goes to MEM.
  - ALU R-type, I-type and lui: goes to WB.
- MEM: iord=1.
  - Load: mem_read=1, then goes to WB.
  - Store: mem_write=1, then goes to FETCH and retires.
- WB: asserts reg_write with class-specific reg_dst and mem_to_reg. Goes to FETCH and retires.
  - jal / bgezal: reg_dst=2, mem_to_reg=2.
  - jalr: reg_dst=1, mem_to_reg=2.
- bgezal writes the link register regardless of br_cond.
- Cycles per instruction: j/jr/nop 2, branch 3, jal/jalr 3, store 4, ALU 4, bgezal 4, load 5.
- Every output not named for a state is 0 in that state.
- alu_ctrl, alu_src and ext_op are also held at their EXEC values during MEM, so the address stays stable.
- retired increments by 1 on each transition into FETCH that ends an instruction. The INIT→FETCH transition does not count. The counter wraps 0xFFFFFFFF→0.

## Timing
- All outputs are combinational decodes of state (plus cmd in DECODE/EXEC/MEM/WB). Only state and retired are registered.
- Asynchronous reset forces state=INIT and retired=0 immediately. All strobes are 0 while reset_n=0.
- Reset asserted mid-instruction (any state) aborts it with no further strobes. The aborted instruction is not counted.
- br_cond is sampled only in EXEC.

## Configuration
- CTRL_MEM_HANDSHAKE_EN defined:
  - FETCH and MEM hold state while mem_ready=0; their strobes stay asserted.
  - pc_write and ir_write in FETCH are qualified by mem_ready.
  - Transitions happen on the edge where mem_ready=1.
- Not defined: mem_ready is ignored. FETCH and MEM each last exactly one cycle.

## Structure
- Shared package (mips_ctrl_pkg) holds:
  - state encodings;
  - opcode/funct/rt constants;
  - the 5-bit ALU codes: ADD 00010, SUB 00011, AND 00100, OR 00101, XOR 00110, NOR 00111, SRL 01000, SRA 01001, SLL 01010, BNE 01011, SLT 01100, SLTU 01101, BLEZ 01110, BGTZ 01111, BLTZ 00000, BGEZ 00001;
  - the instruction-class encoding.
- One sub-module, mc_ctrl_decode: purely combinational. Maps cmd to the instruction class plus the per-class alu_ctrl, alu_src, ext_op, reg_dst and link flag.
- The FSM and counter stay in mc_ctrl.

## Test plan
- Reset, then addu $3,$1,$2 (0x00221821): states 1,2,3,5,1. WB has reg_write=1, reg_dst=1, alu_ctrl=00010. retired=1.
- lw with handshake enabled and mem_ready low for 2 cycles in MEM: MEM lasts 3 cycles with mem_read=1, iord=1. WB has mem_to_reg=1. Total 7 cycles.
- beq with br_cond=1, then with br_cond=0: EXEC pc_write=1/pc_src=1 versus pc_write=0. Both take 3 cycles.
- jal 0x0040_0010: DECODE pc_write=1, pc_src=2. WB reg_dst=2, mem_to_reg=2, reg_write=1.
- reset_n pulled low during MEM of sw: mem_write drops to 0 in the same cycle, state=0, retired unchanged at 0.
- Opcode 0x3F and cmd=0: states 1,2,1. No strobes in DECODE. retired increments.
